// File: rtl/booth4_multdiv_mult.sv
// Signed WIDTH x WIDTH multiplier, radix-4 Booth recoding, two multiplier bits per clock.
// The running multiplicand advances through a shift-left-by-two each iteration.
// Optional: define MULT_EARLY_TERM_EN to finish as soon as the remaining Booth digits are all zero.
module booth4_multdiv_mult #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    m_q, m_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             qm1_q, qm1_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [W2-1:0]    pp;
  logic [W2-1:0]    m2;
  logic [W2-1:0]    acc_nxt;
  logic [W2-1:0]    fin;
  logic [WIDTH:0]   fin_hi;
  logic             last_iter;
  logic             early;
  logic             finish;

  // Booth digit selection, accumulation and completion detection
  always_comb begin
    m2 = {m_q[W2-2:0], 1'b0};
    pp = '0;
    case ({b_q[1:0], qm1_q})
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m_q;
      default:        pp = '0;
    endcase
    acc_nxt   = acc_q + pp;
    last_iter = (cnt_q == CW'(ITERS - 1));
`ifdef MULT_EARLY_TERM_EN
    // Remaining digits are all zero once Q and q-1 are a uniform sign fill.
    early = (&{b_q, qm1_q}) | ~(|{b_q, qm1_q});
`else
    early = 1'b0;
`endif
    finish = (state_q == S_RUN) && (early || last_iter);
    fin    = early ? acc_q : acc_nxt;
    fin_hi = fin[W2-1:WIDTH-1];
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      b_q     <= '0;
      qm1_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      b_q     <= b_d;
      qm1_q   <= qm1_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state: a start pulse wins in every state, so it also aborts a multiply in flight
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   state_d = finish ? S_DONE : S_RUN;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand load, one Booth step per RUN cycle, and result capture on the final step
  always_comb begin
    cnt_d = cnt_q;
    m_d   = m_q;
    b_d   = b_q;
    qm1_d = qm1_q;
    acc_d = acc_q;
    res_d = res_q;
    exc_d = exc_q;
    rdy_d = 1'b0;
    if (ctrl_MULT) begin
      cnt_d = '0;
      m_d   = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      b_d   = data_operandB;
      qm1_d = 1'b0;
      acc_d = '0;
    end else if (finish) begin
      res_d = fin[WIDTH-1:0];
      exc_d = ~((&fin_hi) | ~(|fin_hi));
      rdy_d = 1'b1;
    end else if (state_q == S_RUN) begin
      acc_d = acc_nxt;
      m_d   = {m_q[W2-3:0], 2'b00};
      qm1_d = b_q[1];
      b_d   = {{2{b_q[WIDTH-1]}}, b_q[WIDTH-1:2]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Outputs come straight from registers
  always_comb begin
    data_result    = res_q;
    data_exception = exc_q;
    data_resultRDY = rdy_q;
  end

endmodule

// File: tb/tb_booth4_multdiv_mult.sv
// Scoreboard bench for booth4_multdiv_mult: the driver pushes the expected product,
// exception flag and completion cycle; a monitor pops and checks on every RDY pulse.
module tb_booth4_multdiv_mult;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;

  booth4_multdiv_mult #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] hold_res = '0;
  logic         hold_exc = 1'b0;
  logic         prev_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Cycles from start edge to RDY: the multiply ends once the unconsumed multiplier
  // bits plus the last consumed bit are a uniform sign fill (early-term build only).
  function automatic int exp_lat(input logic [W-1:0] bv);
    int s;
    int t;
    int early_lat;
    s = $signed(bv);
    early_lat = 16;
    for (int k = 15; k >= 0; k--) begin
      if (k == 0) begin
        if (s == 0) early_lat = 1;
      end else begin
        t = s >>> (2 * k - 1);
        if (t == 0 || t == -1) early_lat = k + 1;
      end
    end
`ifdef MULT_EARLY_TERM_EN
    return early_lat;
`else
    return (early_lat > 0) ? 16 : 16;
`endif
  endfunction

  // Presents operands with a start pulse for exactly one rising edge, then records the expectation.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint p;
    opa = av;
    opb = bv;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    p = longint'($signed(av)) * longint'($signed(bv));
    e.res = p[W-1:0];
    e.exc = (p != longint'($signed(e.res)));
    e.due = cyc + exp_lat(bv);
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clock);
      #1;
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL completion_timeout: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom;
      1:       v = W'($urandom_range(0, 200)) - W'(100);
      2:       v = 32'h8000_0000;
      3:       v = ($urandom_range(0, 1) != 0) ? '1 : '0;
      default: v = W'(1) << $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // Monitor: checks every completion against the scoreboard and that outputs hold otherwise
  always @(negedge clock) begin
    if (reset) begin
      chk("reset_result", data_result, 0);
      chk("reset_exception", data_exception, 0);
      chk("reset_rdy", data_resultRDY, 0);
      hold_res = '0;
      hold_exc = 1'b0;
      prev_rdy = 1'b0;
    end else if (data_resultRDY) begin
      chk("rdy_single_cycle", prev_rdy, 0);
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rdy: actual result=%0h with no pending multiply", data_result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", data_result, mon_e.res);
        chk("exception", data_exception, mon_e.exc);
        chk("rdy_cycle", cyc, mon_e.due);
        hold_res = mon_e.res;
        hold_exc = mon_e.exc;
      end
      prev_rdy = 1'b1;
    end else begin
      chk("held_result", data_result, hold_res);
      chk("held_exception", data_exception, hold_exc);
      prev_rdy = 1'b0;
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;

    issue(32'd7, 32'd6);                   wait_done();
    issue(32'hFFFF_FFFD, 32'd5);           wait_done();
    issue(32'h0001_0000, 32'h0001_0000);   wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
    issue(32'h8000_0000, 32'd1);           wait_done();
    issue(32'd5, 32'd0);                   wait_done();
    issue(32'hFFFF_FFFF, 32'h8000_0000);   wait_done();

    // Reset in the middle of a multiply: nothing completes, outputs return to zero
    issue(32'd9, 32'd9);
    repeat (4) @(negedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    #1;
    reset = 1'b0;
    chk("post_reset_result", data_result, 0);
    chk("post_reset_exception", data_exception, 0);
    chk("post_reset_rdy", data_resultRDY, 0);
    issue(32'd2, 32'd3);
    wait_done();

    // Restart while running: only the second multiply completes
    issue(32'd9, 32'd9);
    repeat (8) @(negedge clock);
    #1;
    if (sb.size() != 0) sb.delete(sb.size() - 1);
    issue(32'd4, 32'd4);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      issue(pick(), pick());
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 15);
        repeat (k) @(negedge clock);
        #1;
        if (sb.size() != 0) sb.delete(sb.size() - 1);
        issue(pick(), pick());
      end
      wait_done();
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
